// File: rtl/memory_arbiter_pkg.sv
// Shared memory-interface types: request function/mask encodings plus the
// arbiter's state and owner enums.
package Bundle;

    typedef enum logic {
        M_XRD = 1'b0,
        M_XWR = 1'b1
    } MemoryWriteSignal;

    typedef enum logic [2:0] {
        MT_X  = 3'd0,
        MT_B  = 3'd1,
        MT_H  = 3'd2,
        MT_W  = 3'd3,
        MT_BU = 3'd4,
        MT_HU = 3'd5
    } MemoryMaskType;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } ArbState;

    typedef enum logic {
        OWN_IMEM = 1'b0,
        OWN_DMEM = 1'b1
    } ArbOwner;

    typedef struct packed {
        logic [31:0]      addr;
        MemoryWriteSignal fcn;
        MemoryMaskType    typ;
        logic [31:0]      data;
    } mem_req_t;

endpackage

// File: rtl/memory_arbiter_pick.sv
// Grant selection: data port wins unless the fetch port has been starved
// for the full limit, in which case a waiting fetch is forced through.
module arbiter_pick (
    input  logic imem_valid,
    input  logic dmem_valid,
    input  logic starve_hit,
    output logic grant_imem,
    output logic grant_dmem
);

    assign grant_imem = imem_valid && (!dmem_valid || starve_hit);
    assign grant_dmem = dmem_valid && !grant_imem;

endmodule

// File: rtl/memory_arbiter.sv
// Two-port (fetch/data) arbiter onto a single backing memory with one
// transaction in flight, fetch starvation guard and response timeout.
module memory_arbiter
    import Bundle::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_req_valid,
    input  logic [31:0]      imem_req_addr,
    output logic             imem_req_ready,
    output logic             imem_resp_valid,
    output logic [31:0]      imem_resp_data,
    output logic             imem_resp_err,
    input  logic             dmem_req_valid,
    input  logic [31:0]      dmem_req_addr,
    input  MemoryWriteSignal dmem_req_fcn,
    input  MemoryMaskType    dmem_req_typ,
    input  logic [31:0]      dmem_req_data,
    output logic             dmem_req_ready,
    output logic             dmem_resp_valid,
    output logic [31:0]      dmem_resp_data,
    output logic             dmem_resp_err,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_req_addr,
    output MemoryWriteSignal mem_req_fcn,
    output MemoryMaskType    mem_req_typ,
    output logic [31:0]      mem_req_data,
    input  logic             mem_resp_valid,
    input  logic [31:0]      mem_resp_data,
    output logic             cmiss_stall
);

    ArbState     state_q, state_d;
    ArbOwner     owner_q, owner_d;
    mem_req_t    req_q, req_d;
    logic [31:0] starve_q, starve_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ivld_q, ivld_d, dvld_q, dvld_d, rerr_q, rerr_d;
    logic        imem_v, dmem_v, grant_imem, grant_dmem;
    logic        starve_hit, tmo_hit, done, abort;

    // Requests are masked during reset so no ready can leak out combinationally.
    assign imem_v     = imem_req_valid && rst_n;
    assign dmem_v     = dmem_req_valid && rst_n;
    assign starve_hit = (starve_q == 32'(STARVE_LIMIT));
    // Decided one cycle early so the registered error pulse lands exactly
    // TIMEOUT_CYCLES after the grant, same alignment as a normal response.
    assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_q + 32'd2 >= 32'(TIMEOUT_CYCLES));

    arbiter_pick u_pick (
        .imem_valid (imem_v),
        .dmem_valid (dmem_v),
        .starve_hit (starve_hit),
        .grant_imem (grant_imem),
        .grant_dmem (grant_dmem)
    );

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        req_d          = req_q;
        starve_d       = starve_q;
        tmo_d          = tmo_q;
        rdata_d        = rdata_q;
        ivld_d         = 1'b0;
        dvld_d         = 1'b0;
        rerr_d         = 1'b0;
        done           = 1'b0;
        abort          = 1'b0;
        imem_req_ready = 1'b0;
        dmem_req_ready = 1'b0;
        mem_req_valid  = 1'b0;
        cmiss_stall    = 1'b1;
        case (state_q)
            IDLE: begin
                imem_req_ready = grant_imem;
                dmem_req_ready = grant_dmem;
                cmiss_stall    = (imem_v && !grant_imem) || (dmem_v && !grant_dmem);
                if (!imem_v)
                    starve_d = '0;
                if (grant_imem) begin
                    starve_d = '0;
                    owner_d  = OWN_IMEM;
                    req_d    = '{addr: imem_req_addr, fcn: M_XRD, typ: MT_W, data: 32'd0};
                    tmo_d    = '0;
                    state_d  = ISSUE;
                end else if (grant_dmem) begin
                    if (imem_v && !starve_hit)
                        starve_d = starve_q + 32'd1;
                    owner_d = OWN_DMEM;
                    req_d   = '{addr: dmem_req_addr, fcn: dmem_req_fcn,
                                typ: dmem_req_typ, data: dmem_req_data};
                    tmo_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Withdraw the request on the abort cycle so memory never
                // accepts a transaction we are about to forget.
                mem_req_valid = !tmo_hit;
                tmo_d         = tmo_q + 32'd1;
                if (tmo_hit) begin
                    done  = 1'b1;
                    abort = 1'b1;
                end else if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                tmo_d = tmo_q + 32'd1;
                if (mem_resp_valid) begin
                    done = 1'b1;
                end else if (tmo_hit) begin
                    done  = 1'b1;
                    abort = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            state_d = IDLE;
            ivld_d  = (owner_q == OWN_IMEM);
            dvld_d  = (owner_q == OWN_DMEM);
            rerr_d  = abort;
            rdata_d = abort ? 32'd0 : mem_resp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IMEM;
            req_q    <= '0;
            starve_q <= '0;
            tmo_q    <= '0;
            rdata_q  <= '0;
            ivld_q   <= 1'b0;
            dvld_q   <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            req_q    <= req_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            rdata_q  <= rdata_d;
            ivld_q   <= ivld_d;
            dvld_q   <= dvld_d;
            rerr_q   <= rerr_d;
        end
    end

    assign mem_req_addr    = req_q.addr;
    assign mem_req_fcn     = req_q.fcn;
    assign mem_req_typ     = req_q.typ;
    assign mem_req_data    = req_q.data;
    assign imem_resp_valid = ivld_q;
    assign dmem_resp_valid = dvld_q;
    assign imem_resp_data  = rdata_q;
    assign dmem_resp_data  = rdata_q;
    assign imem_resp_err   = rerr_q && ivld_q;
    assign dmem_resp_err   = rerr_q && dvld_q;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, max cycles from grant to response before abort; 0 SHALL disable timeout.
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive dmem wins over a waiting imem before imem is forced.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_req_valid  in  1 / imem_req_addr  in  32 / imem_req_ready  out  1  fetch request handshake, read-only.
REQ-006 imem_resp_valid  out  1 / imem_resp_data  out  32 / imem_resp_err  out  1  fetch response, one-cycle pulse.
REQ-007 dmem_req_valid  in  1 / dmem_req_addr  in  32 / dmem_req_fcn  in  Bundle::MemoryWriteSignal / dmem_req_typ  in  Bundle::MemoryMaskType / dmem_req_data  in  32 / dmem_req_ready  out  1  data request handshake.
REQ-008 dmem_resp_valid  out  1 / dmem_resp_data  out  32 / dmem_resp_err  out  1  data response, one-cycle pulse.
REQ-009 mem_req_valid  out  1 / mem_req_ready  in  1 / mem_req_addr  out  32 / mem_req_fcn, mem_req_typ  out  Bundle types / mem_req_data  out  32  shared backing-memory request.
REQ-010 mem_resp_valid  in  1 / mem_resp_data  in  32  backing-memory response, arbitrary latency, one per accepted request.
REQ-011 cmiss_stall  out  1  pipeline freeze request to control.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT; exactly one transaction outstanding.
REQ-013 IDLE: if any req_valid, grant one, assert only the winner's req_ready combinationally that cycle, latch addr/fcn/typ/data/owner, go ISSUE; loser ready=0; ready=0 in ISSUE and WAIT.
REQ-014 Priority: dmem over imem, except when starve counter == STARVE_LIMIT and imem_req_valid, imem wins.
REQ-015 Starve counter: +1 per dmem grant while imem_req_valid high; cleared on imem grant or on IDLE arbitration with imem_req_valid low; saturates at STARVE_LIMIT.
REQ-016 imem transactions SHALL drive mem_req_fcn = M_XRD, mem_req_typ = MT_W, mem_req_data = 0.
REQ-017 ISSUE: mem_req_valid=1 with latched fields, held stable until mem_req_ready; on mem_req_ready go WAIT.
REQ-018 WAIT: on mem_resp_valid, register owner's resp_valid=1, resp_data=mem_resp_data, resp_err=0 for exactly one cycle; go IDLE.
REQ-019 Writes complete like reads: dmem_resp_valid pulses on the memory ack, data passed through unchanged.
REQ-020 Latency: grant cycle N, mem_req_valid from N+1; memory accept at N+1 and response at N+2 give requester resp_valid at N+3; new grant may occur in the same cycle as that pulse.
REQ-021 Timeout counter clears on grant, increments each ISSUE/WAIT cycle; reaching TIMEOUT_CYCLES aborts: owner resp_valid=1, resp_err=1, resp_data=0, go IDLE, mem_req_valid drops.
REQ-022 mem_resp_valid coincident with timeout SHALL win: normal response, no error.
REQ-023 mem_resp_valid in IDLE or ISSUE SHALL be ignored (late/spurious response dropped).
REQ-024 cmiss_stall = (state != IDLE) OR (IDLE with a valid requester not granted this cycle).
REQ-025 Requester deasserting valid after grant has no effect on the latched transaction.

Reset
REQ-026 rst_n low SHALL immediately force IDLE; all ready/valid/err outputs, cmiss_stall, latched fields and both counters to 0.
REQ-027 Reset mid-transaction drops it silently; no response pulse follows release.

Structure
REQ-028 ArbState enum (IDLE, ISSUE, WAIT) and ArbOwner enum (OWN_IMEM, OWN_DMEM) SHALL live in Bundle; MemoryWriteSignal/MemoryMaskType reused from Bundle.
REQ-029 Grant selection (priority plus starve override) SHALL be one combinational sub-module, arbiter_pick; counters and FSM in memory_arbiter.

Verification
REQ-030 Both valid at reset release, dmem addr 0x100, imem addr 0x0 -> dmem_req_ready=1, mem_req_addr=0x100 next cycle, imem_req_ready=0, cmiss_stall=1.
REQ-031 dmem and imem held valid continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-032 Single imem read 0x40, memory ready immediately, response 0xDEADBEEF one cycle later -> imem_resp_valid one-cycle pulse, data 0xDEADBEEF, 3 cycles after grant.
REQ-033 TIMEOUT_CYCLES=8, memory never responds -> owner resp_valid with resp_err=1, data 0, 8 cycles after grant; later mem_resp_valid ignored.
REQ-034 rst_n pulsed low during WAIT, memory responds after release -> no resp_valid, state IDLE, all outputs 0.
REQ-035 mem_resp_valid on the timeout cycle, data 0x12345678 -> resp_err=0, data 0x12345678.
